// File: rtl/video_chunk_requester.sv
// video_chunk_requester
// Fetches one source line for the scaler: issues {vPos, chunkNum} requests into
// the source block's request FIFO, drains RGB565 pixels from its response FIFO
// into a line buffer at {chunkNum, pixelIndex}, and pulses lineDone once the
// whole line has been written. In-flight chunks are capped so the response
// FIFO can never overflow.
//
// Ports
//   scalerClock, reset           sole clock; asynchronous active-high reset
//   lineRequestValid/Ready       line handshake (Ready high only when idle)
//   lineRequestVPos              source line number
//   lineRequestChunks            chunks in the line (clamped to 2^(11-CHUNK_BITS))
//   requestFifoWriteEnable/Data  request FIFO write port, data = {vPos, chunkNum}
//   requestFifoFull              request FIFO full flag
//   responseFifoReadEnable       combinational read strobe, data valid next cycle
//   responseFifoEmpty/ReadData   response FIFO status and pixel data
//   lineBufferWrite*             line buffer write port
//   lineDone                     one-cycle pulse when the line is complete
module video_chunk_requester #(
  parameter int unsigned CHUNK_BITS      = 5,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                    scalerClock,
  input  logic                    reset,
  input  logic                    lineRequestValid,
  input  logic [10:0]             lineRequestVPos,
  input  logic [11-CHUNK_BITS:0]  lineRequestChunks,
  output logic                    lineRequestReady,
  output logic                    requestFifoWriteEnable,
  input  logic                    requestFifoFull,
  output logic [21-CHUNK_BITS:0]  requestFifoWriteData,
  output logic                    responseFifoReadEnable,
  input  logic                    responseFifoEmpty,
  input  logic [15:0]             responseFifoReadData,
  output logic                    lineBufferWriteEnable,
  output logic [10:0]             lineBufferWriteAddress,
  output logic [15:0]             lineBufferWriteData,
  output logic                    lineDone
);

  localparam int unsigned CHUNKNUM_W = 11 - CHUNK_BITS;
  localparam int unsigned TOTAL_W    = CHUNKNUM_W + 1;
  localparam int unsigned MAX_CHUNKS = 1 << CHUNKNUM_W;
  localparam int unsigned OUT_W      = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t               state;
  logic [10:0]          vpos;
  logic [TOTAL_W-1:0]   total;
  logic [TOTAL_W-1:0]   chunks_issued;
  logic [OUT_W-1:0]     outstanding;
  logic [11:0]          read_count;
  logic [11:0]          write_count;
  logic                 read_valid;

  logic                 accept;
  logic                 issue;
  logic                 retire;
  logic [TOTAL_W-1:0]   clamped_total;
  logic [11:0]          line_pixels;

  // Handshake, clamp, and engine enables
  always_comb begin
    accept        = 1'b0;
    issue         = 1'b0;
    retire        = 1'b0;
    clamped_total = lineRequestChunks;
    line_pixels   = {total, {CHUNK_BITS{1'b0}}};

    accept = (state == IDLE) && lineRequestValid;
    if (lineRequestChunks > TOTAL_W'(MAX_CHUNKS)) begin
      clamped_total = TOTAL_W'(MAX_CHUNKS);
    end

    // Back-to-back writes are blocked so a full flag that lags one write is harmless
    issue = (state == ACTIVE) && (chunks_issued < total) &&
            (outstanding < OUT_W'(MAX_OUTSTANDING)) &&
            !requestFifoFull && !requestFifoWriteEnable;

    // The last pixel of a chunk frees its response FIFO space
    retire = read_valid && (write_count[CHUNK_BITS-1:0] == {CHUNK_BITS{1'b1}});

    responseFifoReadEnable = (state == ACTIVE) && !responseFifoEmpty &&
                             (read_count < line_pixels);
  end

  // Line sequencing FSM
  always_ff @(posedge scalerClock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      vpos             <= '0;
      total            <= '0;
      lineRequestReady <= 1'b1;
      lineDone         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          lineDone <= 1'b0;
          if (lineRequestValid) begin
            vpos             <= lineRequestVPos;
            total            <= clamped_total;
            lineRequestReady <= 1'b0;
            if (clamped_total == '0) begin
              state    <= DONE;
              lineDone <= 1'b1;
            end else begin
              state <= ACTIVE;
            end
          end
        end
        ACTIVE: begin
          if (write_count == line_pixels) begin
            state    <= DONE;
            lineDone <= 1'b1;
          end
        end
        DONE: begin
          state            <= IDLE;
          lineDone         <= 1'b0;
          lineRequestReady <= 1'b1;
        end
        default: begin
          state            <= IDLE;
          lineDone         <= 1'b0;
          lineRequestReady <= 1'b1;
        end
      endcase
    end
  end

  // Request engine and in-flight chunk accounting
  always_ff @(posedge scalerClock or posedge reset) begin
    if (reset) begin
      requestFifoWriteEnable <= 1'b0;
      requestFifoWriteData   <= '0;
      chunks_issued          <= '0;
      outstanding            <= '0;
    end else begin
      requestFifoWriteEnable <= issue;
      if (accept) begin
        chunks_issued <= '0;
        outstanding   <= '0;
      end else begin
        if (issue) begin
          requestFifoWriteData <= {vpos, chunks_issued[CHUNKNUM_W-1:0]};
          chunks_issued        <= chunks_issued + TOTAL_W'(1);
        end
        if (issue && !retire) begin
          outstanding <= outstanding + OUT_W'(1);
        end else if (!issue && retire) begin
          outstanding <= outstanding - OUT_W'(1);
        end
      end
    end
  end

  // Read engine: strobe -> data valid -> line buffer write
  always_ff @(posedge scalerClock or posedge reset) begin
    if (reset) begin
      read_count             <= '0;
      write_count            <= '0;
      read_valid             <= 1'b0;
      lineBufferWriteEnable  <= 1'b0;
      lineBufferWriteAddress <= '0;
      lineBufferWriteData    <= '0;
    end else begin
      read_valid            <= responseFifoReadEnable;
      lineBufferWriteEnable <= read_valid;
      if (accept) begin
        read_count  <= '0;
        write_count <= '0;
      end else begin
        if (responseFifoReadEnable) begin
          read_count <= read_count + 12'(1);
        end
        if (read_valid) begin
          lineBufferWriteAddress <= write_count[10:0];
          lineBufferWriteData    <= responseFifoReadData;
          write_count            <= write_count + 12'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_video_chunk_requester.sv
// Bench for video_chunk_requester: models the source block (request FIFO sink,
// delayed chunk responses into a response FIFO) and checks request order,
// line buffer address/data stream, in-flight limit, lineDone timing and reset.
module tb_video_chunk_requester;

  localparam int MAX_OUT   = 2;
  localparam int CHUNK_PIX = 32;
  localparam int MAX_CHUNK = 64;

  logic        clk;
  logic        reset;
  logic        lineRequestValid;
  logic [10:0] lineRequestVPos;
  logic [6:0]  lineRequestChunks;
  logic        lineRequestReady;
  logic        requestFifoWriteEnable;
  logic        requestFifoFull;
  logic [16:0] requestFifoWriteData;
  logic        responseFifoReadEnable;
  logic        responseFifoEmpty;
  logic [15:0] responseFifoReadData;
  logic        lineBufferWriteEnable;
  logic [10:0] lineBufferWriteAddress;
  logic [15:0] lineBufferWriteData;
  logic        lineDone;

  video_chunk_requester dut (
    .scalerClock            (clk),
    .reset                  (reset),
    .lineRequestValid       (lineRequestValid),
    .lineRequestVPos        (lineRequestVPos),
    .lineRequestChunks      (lineRequestChunks),
    .lineRequestReady       (lineRequestReady),
    .requestFifoWriteEnable (requestFifoWriteEnable),
    .requestFifoFull        (requestFifoFull),
    .requestFifoWriteData   (requestFifoWriteData),
    .responseFifoReadEnable (responseFifoReadEnable),
    .responseFifoEmpty      (responseFifoEmpty),
    .responseFifoReadData   (responseFifoReadData),
    .lineBufferWriteEnable  (lineBufferWriteEnable),
    .lineBufferWriteAddress (lineBufferWriteAddress),
    .lineBufferWriteData    (lineBufferWriteData),
    .lineDone               (lineDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  // Source-block model and expected line state
  logic [15:0] fifo_q[$];
  logic [15:0] exp_pix[$];
  int          pend_ready[$];
  int          resp_delay;
  bit          stall_mode;
  bit          full_force;
  bit          rd_prev;
  bit          full_prev;
  int          exp_vpos, exp_total, next_chunk, exp_addr;
  int          reqs, writes, dones, last_wr_cycle, done_cycle, accept_cycle;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: perform the read the DUT strobes, then check outputs
  task automatic tick();
    bit          rd;
    logic [15:0] rdata;
    logic [16:0] e;
    logic [15:0] p;
    int          o;
    rd = 1'b0;
    rdata = 16'h0;
    #1;
    rd = responseFifoReadEnable;
    if (rd) begin
      chk("read_not_empty", 32'(responseFifoEmpty), 32'd0);
      if (fifo_q.size() > 0) rdata = fifo_q.pop_front();
      else rdata = 16'hDEAD;
    end
    @(posedge clk);
    #1;
    if (rd) responseFifoReadData = rdata;
    @(negedge clk);
    cycle++;

    chk("wr_follows_rd", 32'(lineBufferWriteEnable), 32'(rd_prev));
    if (lineBufferWriteEnable === 1'b1) begin
      chk("wr_addr", 32'(lineBufferWriteAddress), 32'(exp_addr));
      if (exp_pix.size() > 0) p = exp_pix.pop_front();
      else p = 16'hBAD0;
      chk("wr_data", 32'(lineBufferWriteData), 32'(p));
      exp_addr++;
      writes++;
      last_wr_cycle = cycle;
    end
    if (requestFifoWriteEnable === 1'b1) begin
      e = {11'(exp_vpos), 6'(next_chunk)};
      chk("req_while_full", 32'(full_prev), 32'd0);
      chk("req_data", 32'(requestFifoWriteData), 32'(e));
      next_chunk++;
      reqs++;
      pend_ready.push_back(cycle + resp_delay);
    end
    o = reqs - writes / CHUNK_PIX;
    chk("outstanding_bound", 32'((o >= 0) && (o <= MAX_OUT)), 32'd1);
    if (lineDone === 1'b1) begin
      dones++;
      done_cycle = cycle;
      chk("done_writes", 32'(writes), 32'(exp_total * CHUNK_PIX));
      chk("done_chunks", 32'(next_chunk), 32'(exp_total));
      if (exp_total > 0) chk("done_after_last_write", 32'(cycle - last_wr_cycle), 32'd1);
    end

    rd_prev   = rd;
    full_prev = requestFifoFull;
    while (pend_ready.size() > 0 && pend_ready[0] <= cycle) begin
      void'(pend_ready.pop_front());
      for (int i = 0; i < CHUNK_PIX; i++) begin
        p = 16'($urandom);
        fifo_q.push_back(p);
        exp_pix.push_back(p);
      end
    end
    responseFifoEmpty = (fifo_q.size() == 0) || (stall_mode && ($urandom_range(0, 1) == 0));
    requestFifoFull   = full_force;
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready",    32'(lineRequestReady),       32'd1);
    chk("rst_req_we",   32'(requestFifoWriteEnable), 32'd0);
    chk("rst_req_data", 32'(requestFifoWriteData),   32'd0);
    chk("rst_rd_en",    32'(responseFifoReadEnable), 32'd0);
    chk("rst_lb_we",    32'(lineBufferWriteEnable),  32'd0);
    chk("rst_lb_addr",  32'(lineBufferWriteAddress), 32'd0);
    chk("rst_lb_data",  32'(lineBufferWriteData),    32'd0);
    chk("rst_done",     32'(lineDone),               32'd0);
  endtask

  // Asynchronous reset: outputs must clear without a clock edge
  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check_reset_outputs();
    fifo_q.delete();
    exp_pix.delete();
    pend_ready.delete();
    rd_prev = 1'b0; full_prev = 1'b0; full_force = 1'b0;
    reqs = 0; writes = 0; exp_addr = 0; next_chunk = 0; dones = 0;
    responseFifoEmpty = 1'b1;
    requestFifoFull = 1'b0;
    responseFifoReadData = 16'h0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic start_line(input int vpos, input int chunks, input int delay, input bit stall);
    exp_vpos = vpos;
    exp_total = (chunks > MAX_CHUNK) ? MAX_CHUNK : chunks;
    next_chunk = 0; exp_addr = 0; reqs = 0; writes = 0; dones = 0;
    last_wr_cycle = 0; done_cycle = -1;
    resp_delay = delay;
    stall_mode = stall;
    chk("ready_before_line", 32'(lineRequestReady), 32'd1);
    lineRequestValid  = 1'b1;
    lineRequestVPos   = 11'(vpos);
    lineRequestChunks = 7'(chunks);
    tick();
    lineRequestValid = 1'b0;
    accept_cycle = cycle;
    chk("ready_low_after_accept", 32'(lineRequestReady), 32'd0);
  endtask

  task automatic finish_line(input int max_cycles, input int full_at);
    int n;
    n = 0;
    while (dones == 0 && n < max_cycles) begin
      if (full_at >= 0 && n == full_at) full_force = 1'b1;
      if (full_at >= 0 && n == full_at + 20) full_force = 1'b0;
      tick();
      n++;
    end
    full_force = 1'b0;
    chk("line_done_seen", 32'(dones), 32'd1);
    tick();
    chk("ready_after_done", 32'(lineRequestReady), 32'd1);
    repeat (3) tick();
    chk("single_done", 32'(dones), 32'd1);
    chk("all_chunks", 32'(next_chunk), 32'(exp_total));
    chk("all_writes", 32'(writes), 32'(exp_total * CHUNK_PIX));
    chk("fifo_drained", 32'(fifo_q.size() + pend_ready.size()), 32'd0);
  endtask

  initial begin
    int n;
    lineRequestValid = 1'b0;
    lineRequestVPos = '0;
    lineRequestChunks = '0;
    requestFifoFull = 1'b0;
    responseFifoEmpty = 1'b1;
    responseFifoReadData = '0;
    full_force = 1'b0;
    stall_mode = 1'b0;
    resp_delay = 3;
    exp_total = 0;
    reset = 1'b0;
    #2;
    apply_reset();

    // Single chunk, quick response
    start_line(5, 1, 3, 1'b0);
    finish_line(500, -1);

    // Full line with slow responses: in-flight limit must hold throughout
    start_line(100, 64, 40, 1'b0);
    finish_line(20000, -1);

    // Request FIFO full held for 20 cycles mid-line
    start_line(777, 8, 5, 1'b0);
    finish_line(3000, 40);

    // Response FIFO empty flag toggled randomly
    start_line(int'($urandom_range(0, 2047)), 6, 4, 1'b1);
    finish_line(5000, -1);

    // Zero-chunk line: no FIFO traffic, immediate done
    start_line(9, 0, 3, 1'b0);
    finish_line(10, -1);
    chk("zero_done_latency", 32'((done_cycle - accept_cycle) <= 1), 32'd1);
    chk("zero_no_traffic", 32'(reqs + writes), 32'd0);

    // Oversized chunk count clamps to a full line
    start_line(int'($urandom_range(0, 2047)), 100, 2, 1'b0);
    finish_line(20000, -1);

    // Reset in the middle of chunk 3, then a fresh line from chunk 0
    start_line(12, 8, 3, 1'b0);
    n = 0;
    while (writes < 3 * CHUNK_PIX + 10 && n < 2000) begin
      tick();
      n++;
    end
    chk("reached_chunk3", 32'(writes), 32'(3 * CHUNK_PIX + 10));
    apply_reset();
    start_line(33, 3, 3, 1'b1);
    finish_line(3000, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
